// File: rtl/audiodac_fifo_mc_pkg.sv
// audiodac_pkg: shared helpers for the multi-channel audio DAC FIFO.
//   frame_width()    - bits in one frame of `channels` samples of `width` bits
//   midscale_frame() - frame with every channel at unsigned midscale (MSB set)
//                      returned in a wide vector; callers cast it to their width
package audiodac_pkg;

    localparam int MAX_FRAME_W = 1024;

    typedef logic [MAX_FRAME_W-1:0] wide_frame_t;

    function automatic int frame_width(input int width, input int channels);
        return width * channels;
    endfunction

    function automatic wide_frame_t midscale_frame(input int width, input int channels);
        wide_frame_t f;
        f = '0;
        for (int ch = 0; ch < channels; ch++) begin
            f[ch * width + width - 1] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/audiodac_fifo_mc_if.sv
// audiodac_fifo_mc_if: frame handshake bundle between sample source,
// FIFO and modulator read side.
//   fifo_indata      source -> FIFO  input frame, channel 0 in LSBs
//   fifo_indata_rdy  source -> FIFO  4-phase request
//   fifo_indata_ack  FIFO -> source  4-phase acknowledge
//   fifo_outdata     FIFO -> reader  registered output frame
//   fifo_outdata_rd  reader -> FIFO  advance to next frame
// master = source/reader side, slave = FIFO side.
interface audiodac_fifo_mc_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
);
    import audiodac_pkg::*;

    localparam int FW = frame_width(WIDTH, CHANNELS);

    logic [FW-1:0] fifo_indata;
    logic          fifo_indata_rdy;
    logic          fifo_indata_ack;
    logic [FW-1:0] fifo_outdata;
    logic          fifo_outdata_rd;

    modport master (
        output fifo_indata,
        output fifo_indata_rdy,
        input  fifo_indata_ack,
        input  fifo_outdata,
        output fifo_outdata_rd
    );

    modport slave (
        input  fifo_indata,
        input  fifo_indata_rdy,
        output fifo_indata_ack,
        output fifo_outdata,
        input  fifo_outdata_rd
    );

endinterface

// File: rtl/audiodac_fifo_mc_sync2.sv
// audiodac_sync2: two flip-flop synchroniser for the source request.
//   clk_i  destination clock
//   rst_i  synchronous active-high reset, clears both stages
//   d_i    asynchronous input
//   q_o    synchronised output (2 edges of latency)
module audiodac_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/audiodac_fifo_mc.sv
// audiodac_fifo_mc: multi-channel frame FIFO in front of the delta-sigma
// modulator. One entry = one frame of CHANNELS samples of WIDTH bits.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   fifo_bus (slave)          frame handshake: indata/rdy/ack, outdata/rd
//   fifo_full_o/empty_o       level == depth / level == 0
//   fifo_level_o              entries stored
//   fifo_afull_thr_i/_o       almost-full threshold / level >= threshold
//   fifo_aempty_thr_i/_o      almost-empty threshold / level <= threshold
//   fifo_overrun_o/underrun_o sticky error flags
//   fifo_flag_clr_i           clears both sticky flags (wins over a set)
//   tst_fifo_loop_i           loop mode: reads recirculate, level frozen
module audiodac_fifo_mc
    import audiodac_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int FIFO_SIZE  = 5,
    parameter int FIFO_ASYNC = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    audiodac_fifo_mc_if.slave    fifo_bus,
    output logic                 fifo_full_o,
    output logic                 fifo_empty_o,
    output logic [FIFO_SIZE:0]   fifo_level_o,
    input  logic [FIFO_SIZE:0]   fifo_afull_thr_i,
    input  logic [FIFO_SIZE:0]   fifo_aempty_thr_i,
    output logic                 fifo_afull_o,
    output logic                 fifo_aempty_o,
    output logic                 fifo_overrun_o,
    output logic                 fifo_underrun_o,
    input  logic                 fifo_flag_clr_i,
    input  logic                 tst_fifo_loop_i
);

    localparam int                   FW        = frame_width(WIDTH, CHANNELS);
    localparam int                   DEPTH     = 2 ** FIFO_SIZE;
    localparam int                   LW        = FIFO_SIZE + 1;
    localparam logic [LW-1:0]        DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]        LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0]        LVL_ONE   = LW'(1);
    localparam logic [FIFO_SIZE-1:0] PTR_ONE   = FIFO_SIZE'(1);
    localparam logic [FW-1:0]        MIDSCALE  = FW'(midscale_frame(WIDTH, CHANNELS));

    logic [FW-1:0]        mem_q [DEPTH];
    logic [FIFO_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ack_q, ack_d;
    logic                 ovr_q, ovr_d;
    logic                 und_q, und_d;
    logic [FW-1:0]        out_q, out_d;

    logic rdy_s;
    logic full_s;
    logic empty_s;
    logic wr_en_s;
    logic ovr_set_s;
    logic rd_ok_s;
    logic pop_s;
    logic und_set_s;

    generate
        if (FIFO_ASYNC != 0) begin : g_sync
            audiodac_sync2 u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (fifo_bus.fifo_indata_rdy),
                .q_o   (rdy_s)
            );
        end else begin : g_direct
            assign rdy_s = fifo_bus.fifo_indata_rdy;
        end
    endgenerate

    // handshake / read qualification; full and empty come from the pre-edge level
    always_comb begin
        full_s    = (level_q == DEPTH_LVL);
        empty_s   = (level_q == LVL_ZERO);
        wr_en_s   = rdy_s & ~ack_q & ~full_s;
        ovr_set_s = rdy_s & ~ack_q & full_s;
        // loop mode may read a never-written slot; that is the test intent
        rd_ok_s   = fifo_bus.fifo_outdata_rd & (tst_fifo_loop_i | ~empty_s);
        pop_s     = fifo_bus.fifo_outdata_rd & ~tst_fifo_loop_i & ~empty_s;
        und_set_s = fifo_bus.fifo_outdata_rd & ~tst_fifo_loop_i & empty_s;
    end

    // next-state for pointers, level, handshake, sticky flags and output
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = ack_q;
        ovr_d    = ovr_q;
        und_d    = und_q;
        out_d    = out_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            out_d    = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            out_d    = out_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // ack only falls once the request is withdrawn: one write per pulse
        if (!rdy_s) begin
            ack_d = 1'b0;
        end else if (wr_en_s) begin
            ack_d = 1'b1;
        end else begin
            ack_d = ack_q;
        end

        if (fifo_flag_clr_i) begin
            ovr_d = 1'b0;
            und_d = 1'b0;
        end else begin
            ovr_d = ovr_q | ovr_set_s;
            und_d = und_q | und_set_s;
        end
    end

    // control state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= LVL_ZERO;
            ack_q    <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
            out_q    <= MIDSCALE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
            out_q    <= out_d;
        end
    end

    // frame storage; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_s && !rst_i) begin
            mem_q[wr_ptr_q] <= fifo_bus.fifo_indata;
        end
    end

    assign fifo_bus.fifo_indata_ack = ack_q;
    assign fifo_bus.fifo_outdata    = out_q;
    assign fifo_full_o              = full_s;
    assign fifo_empty_o             = empty_s;
    assign fifo_level_o             = level_q;
    assign fifo_afull_o             = (level_q >= fifo_afull_thr_i);
    assign fifo_aempty_o            = (level_q <= fifo_aempty_thr_i);
    assign fifo_overrun_o           = ovr_q;
    assign fifo_underrun_o          = und_q;

endmodule

// File: tb/tb_audiodac_fifo_mc.sv
// Bench for audiodac_fifo_mc: table-driven per-cycle vectors on a
// FIFO_ASYNC=0 instance plus hand sequences for request latency on both a
// FIFO_ASYNC=0 and a FIFO_ASYNC=1 instance (WIDTH=16, CHANNELS=2, FIFO_SIZE=3).
module tb_audiodac_fifo_mc;

    localparam logic [31:0] MID = 32'h8000_8000;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic        lp;
        logic        clr;
        logic [31:0] din;
        logic [31:0] exp_out;
        int          exp_level;
        logic        exp_ack;
        logic        exp_ovr;
        logic        exp_und;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    audiodac_fifo_mc_if #(.WIDTH(16), .CHANNELS(2)) bus1 ();
    audiodac_fifo_mc_if #(.WIDTH(16), .CHANNELS(2)) bus2 ();

    logic       full1, empty1, afull1, aempty1, ovr1, und1, clr1, loop1;
    logic [3:0] level1;
    logic       full2, empty2, afull2, aempty2, ovr2, und2;
    logic [3:0] level2;
    logic [3:0] afull_thr  = 4'd6;
    logic [3:0] aempty_thr = 4'd2;
    logic       tie0       = 1'b0;

    always #5 clk = ~clk;

    audiodac_fifo_mc #(.WIDTH(16), .CHANNELS(2), .FIFO_SIZE(3), .FIFO_ASYNC(0)) dut_sync (
        .clk_i             (clk),
        .rst_i             (rst),
        .fifo_bus          (bus1.slave),
        .fifo_full_o       (full1),
        .fifo_empty_o      (empty1),
        .fifo_level_o      (level1),
        .fifo_afull_thr_i  (afull_thr),
        .fifo_aempty_thr_i (aempty_thr),
        .fifo_afull_o      (afull1),
        .fifo_aempty_o     (aempty1),
        .fifo_overrun_o    (ovr1),
        .fifo_underrun_o   (und1),
        .fifo_flag_clr_i   (clr1),
        .tst_fifo_loop_i   (loop1)
    );

    audiodac_fifo_mc #(.WIDTH(16), .CHANNELS(2), .FIFO_SIZE(3), .FIFO_ASYNC(1)) dut_async (
        .clk_i             (clk),
        .rst_i             (rst),
        .fifo_bus          (bus2.slave),
        .fifo_full_o       (full2),
        .fifo_empty_o      (empty2),
        .fifo_level_o      (level2),
        .fifo_afull_thr_i  (afull_thr),
        .fifo_aempty_thr_i (aempty_thr),
        .fifo_afull_o      (afull2),
        .fifo_aempty_o     (aempty2),
        .fifo_overrun_o    (ovr2),
        .fifo_underrun_o   (und2),
        .fifo_flag_clr_i   (tie0),
        .tst_fifo_loop_i   (tie0)
    );

    function automatic logic [31:0] frm(input int n);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = 16'(n);
        lo = 16'h1000 + 16'(n);
        return {hi, lo};
    endfunction

    task automatic add(input logic rst_v, input logic rdy, input logic rd, input logic lp,
                       input logic clr, input logic [31:0] din, input logic [31:0] exp_out,
                       input int lvl, input logic ack, input logic ovr, input logic und);
        vec_t v;
        v.rst = rst_v; v.rdy = rdy; v.rd = rd; v.lp = lp; v.clr = clr; v.din = din;
        v.exp_out = exp_out; v.exp_level = lvl; v.exp_ack = ack; v.exp_ovr = ovr; v.exp_und = und;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build_table();
        int loop_seq[10] = '{21, 22, 23, 12, 5, 6, 7, 8, 21, 22};
        // reset
        add(1, 0, 0, 0, 0, 32'h0, MID, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 32'h0, MID, 0, 0, 0, 0);
        // fill to full with 4-phase writes
        for (int i = 1; i <= 8; i++) begin
            add(0, 1, 0, 0, 0, frm(i), MID, i, 1, 0, 0);
            add(0, 0, 0, 0, 0, frm(i), MID, i, 0, 0, 0);
        end
        // overrun while full, then a read frees space and the write completes
        add(0, 1, 0, 0, 0, frm(9), MID, 8, 0, 1, 0);
        add(0, 1, 0, 0, 0, frm(9), MID, 8, 0, 1, 0);
        add(0, 1, 1, 0, 0, frm(9), frm(1), 7, 0, 1, 0);
        add(0, 1, 0, 0, 0, frm(9), frm(1), 8, 1, 1, 0);
        add(0, 0, 0, 0, 0, frm(9), frm(1), 8, 0, 1, 0);
        add(0, 0, 0, 0, 1, frm(9), frm(1), 8, 0, 0, 0);
        // drain
        for (int n = 2; n <= 9; n++) begin
            add(0, 0, 1, 0, 0, 32'h0, frm(n), 9 - n, 0, 0, 0);
        end
        // underrun holds last frame, clear
        add(0, 0, 1, 0, 0, 32'h0, frm(9), 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 32'h0, frm(9), 0, 0, 0, 0);
        // simultaneous read+write non-empty, then empty+simultaneous
        add(0, 1, 0, 0, 0, frm(10), frm(9), 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, frm(10), frm(9), 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, frm(11), frm(10), 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, frm(11), frm(10), 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 32'h0, frm(11), 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, frm(12), frm(11), 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, frm(12), frm(11), 1, 0, 0, 1);
        add(0, 0, 1, 0, 1, 32'h0, frm(12), 0, 0, 0, 0);
        // clear wins over a same-cycle underrun
        add(0, 0, 1, 0, 1, 32'h0, frm(12), 0, 0, 0, 0);
        // reset, write 3 frames, loop mode
        add(1, 0, 0, 0, 0, 32'h0, MID, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            add(0, 1, 0, 0, 0, frm(20 + k), MID, k, 1, 0, 0);
            add(0, 0, 0, 0, 0, frm(20 + k), MID, k, 0, 0, 0);
        end
        for (int r = 0; r < 10; r++) begin
            add(0, 0, 1, 1, 0, 32'h0, frm(loop_seq[r]), 3, 0, 0, 0);
        end
        // write during loop mode, then a normal read of it
        add(0, 1, 1, 1, 0, frm(24), frm(23), 4, 1, 0, 0);
        add(0, 0, 0, 1, 0, frm(24), frm(23), 4, 0, 0, 0);
        add(0, 0, 1, 0, 0, 32'h0, frm(24), 3, 0, 0, 0);
    endtask

    task automatic count_ack(input int which, input logic target, input int exp_edges, input string name);
        int   n;
        logic a;
        n = 0;
        a = (which == 1) ? bus1.fifo_indata_ack : bus2.fifo_indata_ack;
        while (n < 10 && a !== target) begin
            @(posedge clk);
            #1;
            n++;
            a = (which == 1) ? bus1.fifo_indata_ack : bus2.fifo_indata_ack;
        end
        check(name, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        vec_t v;
        string tag;
        bus1.fifo_indata = 32'h0; bus1.fifo_indata_rdy = 1'b0; bus1.fifo_outdata_rd = 1'b0;
        bus2.fifo_indata = 32'h0; bus2.fifo_indata_rdy = 1'b0; bus2.fifo_outdata_rd = 1'b0;
        clr1 = 1'b0; loop1 = 1'b0;

        build_table();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst;
            bus1.fifo_indata_rdy = v.rdy;
            bus1.fifo_outdata_rd = v.rd;
            bus1.fifo_indata     = v.din;
            loop1 = v.lp;
            clr1  = v.clr;
            @(posedge clk);
            #1;
            tag = $sformatf("v%0d", i);
            check({tag, " out"},    bus1.fifo_outdata, v.exp_out);
            check({tag, " level"},  32'(level1), 32'(v.exp_level));
            check({tag, " ack"},    32'(bus1.fifo_indata_ack), 32'(v.exp_ack));
            check({tag, " ovr"},    32'(ovr1), 32'(v.exp_ovr));
            check({tag, " und"},    32'(und1), 32'(v.exp_und));
            check({tag, " full"},   32'(full1), 32'(v.exp_level == 8));
            check({tag, " empty"},  32'(empty1), 32'(v.exp_level == 0));
            check({tag, " afull"},  32'(afull1), 32'(v.exp_level >= 6));
            check({tag, " aempty"}, 32'(aempty1), 32'(v.exp_level <= 2));
        end
        rst = 1'b0; bus1.fifo_indata_rdy = 1'b0; bus1.fifo_outdata_rd = 1'b0;
        loop1 = 1'b0; clr1 = 1'b0;

        // async instance idle after reset
        check("async reset out", bus2.fifo_outdata, MID);
        check("async reset level", 32'(level2), 32'd0);

        // sync request latency: 1 edge up, 1 edge down
        bus1.fifo_indata = frm(25);
        bus1.fifo_indata_rdy = 1'b1;
        count_ack(1, 1'b1, 1, "sync ack rise");
        check("sync level after write", 32'(level1), 32'd4);
        bus1.fifo_indata_rdy = 1'b0;
        count_ack(1, 1'b0, 1, "sync ack fall");

        // async request latency: 3 edges up, 3 edges down
        bus2.fifo_indata = frm(30);
        bus2.fifo_indata_rdy = 1'b1;
        count_ack(2, 1'b1, 3, "async ack rise");
        check("async level after write", 32'(level2), 32'd1);
        bus2.fifo_indata_rdy = 1'b0;
        count_ack(2, 1'b0, 3, "async ack fall");
        check("async one write per pulse", 32'(level2), 32'd1);
        bus2.fifo_outdata_rd = 1'b1;
        @(posedge clk);
        #1;
        bus2.fifo_outdata_rd = 1'b0;
        check("async read out", bus2.fifo_outdata, frm(30));
        check("async empty after read", 32'(empty2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audiodac_fifo_mc.md
# audiodac_fifo_mc

Multi-channel, parametrised successor FIFO for the audio DAC datapath: buffers frames of CHANNELS samples (each WIDTH bits) between the sample source (I2S/bus side, optionally asynchronous) and the delta-sigma modulator read side. Adds full-depth usage via a level counter, programmable almost-full/almost-empty thresholds, a fill-level output, sticky overrun/underrun flags and a registered output with midscale reset. It replaces the single-channel FIFO in front of the modulator.

## Interface
- WIDTH, 16, bits per channel sample (unsigned, midscale = 1 followed by zeros)
- CHANNELS, 2, samples per frame; one FIFO entry holds one frame
- FIFO_SIZE, 5, log2 depth; depth = 2^FIFO_SIZE entries, all usable
- FIFO_ASYNC, 1, 1 = rdy is synchronised through 2 FFs; 0 = rdy is used directly
- clk_i  in  1  FIFO clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- fifo_indata_i  in  CHANNELS*WIDTH  input frame, channel 0 in LSBs
- fifo_indata_rdy_i  in  1  source has a frame (4-phase req)
- fifo_indata_ack_o  out  1  frame taken (4-phase ack)
- fifo_outdata_o  out  CHANNELS*WIDTH  current output frame (registered)
- fifo_outdata_rd_i  in  1  advance to next frame
- fifo_full_o / fifo_empty_o  out  1  level == depth / level == 0
- fifo_level_o  out  FIFO_SIZE+1  entries stored
- fifo_afull_thr_i / fifo_aempty_thr_i  in  FIFO_SIZE+1  thresholds
- fifo_afull_o / fifo_aempty_o  out  1  level >= afull_thr / level <= aempty_thr
- fifo_overrun_o / fifo_underrun_o  out  1  sticky error flags
- fifo_flag_clr_i  in  1  clears both sticky flags
- tst_fifo_loop_i  in  1  loop test mode

## Operation
- Reset (rst_i=1 at an edge): pointers, level 0, ack 0, sync FFs 0, sticky flags 0, fifo_outdata_o = midscale in every channel; memory contents not reset. Reset mid-transfer abandons it; source must drop rdy and restart.
- Write: when rdy_s (synced or direct) = 1, ack = 0, not full: store fifo_indata_i at write_ptr, write_ptr++, level++, ack <= 1. Data is sampled directly (stable under 4-phase protocol). ack <= 0 when rdy_s = 0. One write per rdy pulse.
- Overrun: rdy_s = 1, ack = 0, full -> overrun <= 1; no write, ack stays 0 (write proceeds once space frees).
- Read (loop = 0): rd_i with level > 0 -> fifo_outdata_o <= mem[read_ptr], read_ptr++, level--. rd_i with level == 0 -> output holds last frame, underrun <= 1.
- Simultaneous read+write on non-empty, non-full: level unchanged. Empty + simultaneous: write occurs, read underruns (no bypass). Full + simultaneous: read occurs, write blocked this cycle (full evaluated on pre-edge level), completes next cycle.
- Loop mode (loop = 1): rd_i loads mem[read_ptr], read_ptr++ modulo depth; level, write_ptr unchanged; no underrun. Writes continue normally.
- Pointers wrap modulo 2^FIFO_SIZE; level saturates by construction (0..depth).
- fifo_flag_clr_i has priority over a same-cycle set.
- Flags full/empty/afull/aempty are combinational from the registered level.

## Timing
- FIFO_ASYNC=0: rdy high sampled at edge N -> write and ack=1 after edge N. FIFO_ASYNC=1: after edge N+2.
- Write at edge N -> level/empty update after edge N; readable at edge N+1.
- Read at edge N -> new fifo_outdata_o valid after edge N (1-cycle latency).
- ack falls 1 (sync) / 3 (async) edges after rdy falls.

## Structure
- Package audiodac_pkg: midscale constant/function per WIDTH, frame-width helper.
- Sub-module audiodac_sync2: 2-FF synchroniser, synchronous active-high reset; instantiated only when FIFO_ASYNC=1.
- Memory as plain register array; level as dedicated counter.

## Test plan
- WIDTH=16, CHANNELS=2, FIFO_SIZE=3: after reset, output = 0x8000_8000, empty=1, level=0, ack=0.
- Write 8 frames 0x0001_1001..0x0008_1008 -> full=1, level=8; 9th rdy -> overrun=1, ack stays 0; one read outputs 0x0001_1001 and 9th write then completes.
- Read from empty after one frame consumed -> output holds last frame, underrun=1; flag_clr -> 0.
- Thresholds afull=6, aempty=2: level 2 -> aempty=1; level 3 -> 0; level 6 -> afull=1.
- FIFO_ASYNC=1: ack rises exactly 3 edges after rdy; FIFO_ASYNC=0: 1 edge.
- Loop mode with 3 frames written: 10 reads cycle through all 8 entries, level stays 3, underrun stays 0.
